// File: rtl/i2c_cmd_pkg.sv
// Command codes, responder FSM states and command-decode helpers shared by
// common_interface initiators and the cinf_slave_model responder.
package i2c_cmd_pkg;

    localparam int unsigned CMD_W = 4;
    localparam int unsigned LEN_W = 8;

    localparam logic [CMD_W-1:0] MAIN_CMD_IDLE = 4'd0;
    localparam logic [CMD_W-1:0] COMPLETE_WR   = 4'd1;
    localparam logic [CMD_W-1:0] WR_WNO_STOP   = 4'd2;
    localparam logic [CMD_W-1:0] COMPLETE_RD   = 4'd3;
    localparam logic [CMD_W-1:0] RD_WNO_STOP   = 4'd4;
    localparam logic [CMD_W-1:0] SET_IDLE      = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_FETCH = 3'd2,
        ST_RD_OUT   = 3'd3,
        ST_DONE     = 3'd4
    } slv_state_e;

    function automatic logic is_wr(input logic [CMD_W-1:0] c);
        return (c == COMPLETE_WR) || (c == WR_WNO_STOP);
    endfunction

    function automatic logic is_rd(input logic [CMD_W-1:0] c);
        return (c == COMPLETE_RD) || (c == RD_WNO_STOP);
    endfunction

    function automatic logic is_nostop(input logic [CMD_W-1:0] c);
        return (c == WR_WNO_STOP) || (c == RD_WNO_STOP);
    endfunction

endpackage

// File: rtl/cinf_slave_model_mem.sv
// DEPTH x DW register array for the responder model: one synchronous write
// port, one registered read port, whole array cleared by async reset.
module cinf_slave_model_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 8,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data holds between fetches so the beat stays stable under stall.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cinf_slave_model.sv
// Responder end of common_interface: accepts commands, sinks write bursts
// into / sources read bursts from a small array, tracks no-stop bus hold.
// Optional CINF_SLAVE_WAIT_EN inserts WAIT_CYC idle cycles before each beat.
module cinf_slave_model
    import i2c_cmd_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 8,
    parameter int unsigned WAIT_CYC = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_vld,
    output logic             cmd_ready,
    input  logic [AW-1:0]    addr,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [DW-1:0]    wr_data,
    input  logic             wr_vld,
    input  logic             wr_last,
    output logic             wr_ready,
    output logic [DW-1:0]    rd_data,
    output logic             rd_vld,
    output logic             rd_last,
    input  logic             rd_ready,
    output logic             bus_held,
    output logic             err
);

    localparam int unsigned IW = $clog2(DEPTH);

    slv_state_e       state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             wr_ready_q, wr_ready_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_last_q, rd_last_d;
    logic             bus_held_q, bus_held_d;
    logic             err_q, err_d;

    logic             cmd_acc;
    logic             wr_beat;
    logic             rd_hs;
    logic             last_beat;
    logic             fetch_go;
    logic             wait_ok;
    logic             wait_ok_d;
    logic [LEN_W-1:0] len_m1;

    assign cmd_acc   = cmd_vld && cmd_ready_q;
    assign wr_beat   = (state_q == ST_WR) && wr_vld && wr_ready_q;
    assign rd_hs     = (state_q == ST_RD_OUT) && rd_vld_q && rd_ready;
    assign len_m1    = len_q - LEN_W'(1);
    assign last_beat = (cnt_q == len_m1);
    assign fetch_go  = (state_q == ST_RD_FETCH) && wait_ok;

    // Only the low index bits of addr select an array entry.
    if (AW > IW) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[AW-1:IW];
    end

`ifdef CINF_SLAVE_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC);

    logic [3:0] wait_q, wait_d;

    // Reload on entering WR/RD_FETCH and after every write beat, then count down.
    always_comb begin
        wait_d = wait_q;
        if (((state_d == ST_WR) || (state_d == ST_RD_FETCH)) &&
            ((state_d != state_q) || wr_beat)) begin
            wait_d = WAIT_LOAD;
        end else if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wait_q <= 4'd0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign wait_ok   = (wait_q == 4'd0);
    assign wait_ok_d = (wait_d == 4'd0);
`else
    logic [3:0] unused_wait_cfg;
    assign unused_wait_cfg = 4'(WAIT_CYC);
    assign wait_ok   = 1'b1;
    assign wait_ok_d = 1'b1;
`endif

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    if (is_wr(cmd)) begin
                        state_d = ST_WR;
                    end else if (is_rd(cmd)) begin
                        state_d = ST_RD_FETCH;
                    end
                end
            end
            ST_WR: begin
                if (wr_beat && (last_beat || wr_last)) begin
                    state_d = ST_DONE;
                end
            end
            ST_RD_FETCH: begin
                if (fetch_go) begin
                    state_d = ST_RD_OUT;
                end
            end
            ST_RD_OUT: begin
                if (rd_hs) begin
                    state_d = last_beat ? ST_DONE : ST_RD_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cmd_d      = cmd_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        bus_held_d = bus_held_q;
        err_d      = 1'b0;

        if (cmd_acc) begin
            cmd_d = cmd;
            ptr_d = addr[IW-1:0];
            len_d = (burst_len == LEN_W'(0)) ? LEN_W'(1) : burst_len;
            cnt_d = LEN_W'(0);
            if (cmd == SET_IDLE) begin
                bus_held_d = 1'b0;
            end else if (!is_wr(cmd) && !is_rd(cmd)) begin
                err_d = 1'b1;
            end
        end

        if (wr_beat) begin
            ptr_d = ptr_q + IW'(1);
            cnt_d = cnt_q + LEN_W'(1);
            if (wr_last && !last_beat) begin
                err_d = 1'b1;
            end
        end

        if (rd_hs) begin
            ptr_d = ptr_q + IW'(1);
            cnt_d = cnt_q + LEN_W'(1);
        end

        if (state_q == ST_DONE) begin
            bus_held_d = is_nostop(cmd_q);
        end

        cmd_ready_d = (state_d == ST_IDLE);
        wr_ready_d  = (state_d == ST_WR) && wait_ok_d;
        rd_vld_d    = (state_d == ST_RD_OUT);
        rd_last_d   = (state_d == ST_RD_OUT) && (cnt_d == (len_d - LEN_W'(1)));
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cmd_q       <= MAIN_CMD_IDLE;
            ptr_q       <= '0;
            len_q       <= LEN_W'(1);
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            bus_held_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            bus_held_q  <= bus_held_d;
            err_q       <= err_d;
        end
    end

    cinf_slave_model_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clock   (clock),
        .rst     (rst),
        .we_i    (wr_beat),
        .waddr_i (ptr_q),
        .wdata_i (wr_data),
        .re_i    (fetch_go),
        .raddr_i (ptr_q),
        .rdata_o (rd_data)
    );

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_vld    = rd_vld_q;
    assign rd_last   = rd_last_q;
    assign bus_held  = bus_held_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cinf_slave_model.sv
// Scoreboard bench for cinf_slave_model: directed bursts push expected read
// beats into a queue; a monitor pops and compares on each read handshake.
module tb_cinf_slave_model;
    import i2c_cmd_pkg::*;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic       clock = 1'b0;
    logic       rst;
    logic [3:0] cmd;
    logic       cmd_vld;
    logic       cmd_ready;
    logic [7:0] addr;
    logic [7:0] burst_len;
    logic [7:0] wr_data;
    logic       wr_vld;
    logic       wr_last;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_vld;
    logic       rd_last;
    logic       rd_ready;
    logic       bus_held;
    logic       err;

    int    n_cmp    = 0;
    int    n_bad    = 0;
    int    err_seen = 0;
    beat_t rd_exp_q[$];
    beat_t mon_e;

    always #5 clock = ~clock;

    cinf_slave_model #(
        .DEPTH    (16),
        .DW       (8),
        .AW       (8),
        .WAIT_CYC (3)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .cmd       (cmd),
        .cmd_vld   (cmd_vld),
        .cmd_ready (cmd_ready),
        .addr      (addr),
        .burst_len (burst_len),
        .wr_data   (wr_data),
        .wr_vld    (wr_vld),
        .wr_last   (wr_last),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .rd_last   (rd_last),
        .rd_ready  (rd_ready),
        .bus_held  (bus_held),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each read handshake against the scoreboard, count err pulses.
    always @(negedge clock) begin
        if (!rst && rd_vld && rd_ready) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected_beat", 32'(rd_vld), 32'd0);
            end else begin
                mon_e = rd_exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(mon_e.data));
                check("rd_last", 32'(rd_last), 32'(mon_e.last));
            end
        end
        if (!rst && err) err_seen++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_cmd(input logic [3:0] c, input logic [7:0] a, input logic [7:0] l);
        int b;
        cmd = c; addr = a; burst_len = l; cmd_vld = 1'b1;
        b = 0;
        while (!cmd_ready && b < 50) begin tick(); b++; end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic write_beats(input logic [31:0] dpack, input int nb, input int last_at);
        int b;
        for (int i = 0; i < nb; i++) begin
            wr_data = dpack[8*i +: 8];
            wr_last = (i == last_at);
            wr_vld  = 1'b1;
            b = 0;
            while (!wr_ready && b < 50) begin tick(); b++; end
            check("wr_ready_wait", 32'(wr_ready), 32'd1);
            tick();
        end
        wr_vld = 1'b0; wr_last = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] c, input logic [7:0] a, input logic [7:0] l,
                           input int nb, input logic [31:0] epack, input int stall);
        beat_t e;
        int    b;
        for (int i = 0; i < nb; i++) begin
            e.last = (i == nb - 1);
            e.data = epack[8*i +: 8];
            rd_exp_q.push_back(e);
        end
        send_cmd(c, a, l);
        for (int i = 0; i < nb; i++) begin
            rd_ready = (i != stall);
            b = 0;
            while (!rd_vld && b < 50) begin tick(); b++; end
            check("rd_vld_wait", 32'(rd_vld), 32'd1);
            if (i == stall) begin
                repeat (5) begin
                    check("stall_data", 32'(rd_data), 32'(epack[8*i +: 8]));
                    check("stall_vld", 32'(rd_vld), 32'd1);
                    check("stall_last", 32'(rd_last), 32'(i == nb - 1));
                    tick();
                end
                rd_ready = 1'b1;
            end
            tick();
            rd_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1'b1; cmd = 4'd0; cmd_vld = 1'b0; addr = 8'd0; burst_len = 8'd0;
        wr_data = 8'd0; wr_vld = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;
        ticks(3);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_vld", 32'(rd_vld), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_bus_held", 32'(bus_held), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        ticks(2);

        // Single-beat write then read back; wr_ready timing after accept.
        send_cmd(COMPLETE_WR, 8'd1, 8'd1);
`ifdef CINF_SLAVE_WAIT_EN
        repeat (3) begin
            check("wr_ready_wait_low", 32'(wr_ready), 32'd0);
            tick();
        end
`endif
        check("wr_ready_after_accept", 32'(wr_ready), 32'd1);
        write_beats(32'h0000_0005, 1, 0);
        ticks(2);
        do_read(COMPLETE_RD, 8'd1, 8'd1, 1, 32'h0000_0005, -1);
        ticks(2);
        check("t1_bus_held", 32'(bus_held), 32'd0);
        check("t1_err_count", 32'(err_seen), 32'd0);

        // No-stop write wrapping past DEPTH-1, then SET_IDLE releases the bus.
        send_cmd(WR_WNO_STOP, 8'd14, 8'd4);
        write_beats(32'hA3A2_A1A0, 4, 99);
        ticks(2);
        check("t2_bus_held_set", 32'(bus_held), 32'd1);
        send_cmd(SET_IDLE, 8'd0, 8'd0);
        check("t2_bus_held_clr", 32'(bus_held), 32'd0);
        check("t2_err_count", 32'(err_seen), 32'd0);
        do_read(COMPLETE_RD, 8'd14, 8'd4, 4, 32'hA3A2_A1A0, -1);
        ticks(2);

        // Read across the wrap with a 5-cycle stall on beat 2.
        do_read(COMPLETE_RD, 8'd15, 8'd3, 3, 32'h00A3_A2A1, 1);
        ticks(2);

        // Early wr_last on beat 2 of 4: one err pulse, two entries written.
        send_cmd(COMPLETE_WR, 8'd4, 8'd4);
        write_beats(32'h4433_2211, 2, 1);
        ticks(2);
        check("t4_err_count", 32'(err_seen), 32'd1);
        check("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t4_wr_ready", 32'(wr_ready), 32'd0);
        do_read(COMPLETE_RD, 8'd4, 8'd4, 4, 32'h0000_2211, -1);
        ticks(2);

        // RD_WNO_STOP holds the bus; a COMPLETE_WR with len 0 (one beat) releases it.
        do_read(RD_WNO_STOP, 8'd4, 8'd1, 1, 32'h0000_0011, -1);
        ticks(2);
        check("t5_bus_held_rd", 32'(bus_held), 32'd1);
        send_cmd(COMPLETE_WR, 8'd8, 8'd0);
        write_beats(32'h0000_0077, 1, 99);
        ticks(2);
        check("t5_bus_held_clr", 32'(bus_held), 32'd0);
        do_read(COMPLETE_RD, 8'd8, 8'd0, 1, 32'h0000_0077, -1);
        ticks(2);

        // Undefined code and MAIN_CMD_IDLE each pulse err once.
        send_cmd(4'd7, 8'd0, 8'd1);
        send_cmd(MAIN_CMD_IDLE, 8'd0, 8'd1);
        ticks(2);
        check("t6_err_count", 32'(err_seen), 32'd3);
        check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t6_bus_held", 32'(bus_held), 32'd0);
        check("t6_rd_vld", 32'(rd_vld), 32'd0);

        // Async reset in the middle of a read burst.
        send_cmd(COMPLETE_RD, 8'd4, 8'd3);
        rd_ready = 1'b0;
        b = 0;
        while (!rd_vld && b < 50) begin tick(); b++; end
        check("t7_rd_vld_before_rst", 32'(rd_vld), 32'd1);
        rst = 1'b1;
        #1;
        check("t7_rst_rd_vld", 32'(rd_vld), 32'd0);
        check("t7_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t7_rst_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst = 1'b0;
        ticks(2);
        do_read(COMPLETE_RD, 8'd4, 8'd1, 1, 32'h0000_0000, -1);
        ticks(3);

        check("scoreboard_empty", 32'(rd_exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
